// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU instruction and data requesters.
// Data has priority; a starvation counter forces an instruction grant after MAX_STARVE data wins.
module mem_port_arbiter #(
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] inst_mem_address,
    input  logic        inst_mem_read,
    input  logic        inst_mem_write,
    input  logic [3:0]  inst_mem_byte_enable,
    input  logic [31:0] inst_mem_wdata,
    output logic [31:0] inst_mem_rdata,
    output logic        inst_mem_resp,

    input  logic [31:0] data_mem_address,
    input  logic        data_mem_read,
    input  logic        data_mem_write,
    input  logic [3:0]  data_mem_byte_enable,
    input  logic [31:0] data_mem_wdata,
    output logic [31:0] data_mem_rdata,
    output logic        data_mem_resp,

    output logic [31:0] pmem_address,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [3:0]  pmem_byte_enable,
    output logic [31:0] pmem_wdata,
    input  logic [31:0] pmem_rdata,
    input  logic        pmem_resp
);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {OWN_INST, OWN_DATA} owner_t;

    localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

    state_t      state, state_nx;
    owner_t      owner, owner_nx;
    logic [3:0]  starve_cnt, starve_cnt_nx;
    logic [31:0] address_nx, wdata_nx;
    logic [3:0]  byte_enable_nx;
    logic        read_nx, write_nx;

    logic inst_pend, data_pend;

    assign inst_pend = inst_mem_read | inst_mem_write;
    assign data_pend = data_mem_read | data_mem_write;

    always_comb begin
        state_nx       = state;
        owner_nx       = owner;
        starve_cnt_nx  = starve_cnt;
        address_nx     = pmem_address;
        byte_enable_nx = pmem_byte_enable;
        wdata_nx       = pmem_wdata;
        read_nx        = pmem_read;
        write_nx       = pmem_write;

        case (state)
            IDLE: begin
                if (inst_pend || data_pend) begin
                    state_nx = BUSY;
                    if (data_pend && (!inst_pend || starve_cnt < STARVE_LIMIT)) begin
                        owner_nx       = OWN_DATA;
                        address_nx     = data_mem_address;
                        byte_enable_nx = data_mem_byte_enable;
                        wdata_nx       = data_mem_wdata;
                        read_nx        = data_mem_read & ~data_mem_write;
                        write_nx       = data_mem_write;
                        // Only a data win over a waiting inst counts as starvation.
                        if (inst_pend && starve_cnt != 4'hF)
                            starve_cnt_nx = starve_cnt + 4'd1;
                    end else begin
                        owner_nx       = OWN_INST;
                        address_nx     = inst_mem_address;
                        byte_enable_nx = inst_mem_byte_enable;
                        wdata_nx       = inst_mem_wdata;
                        read_nx        = inst_mem_read & ~inst_mem_write;
                        write_nx       = inst_mem_write;
                        starve_cnt_nx  = '0;
                    end
                end
            end
            BUSY: begin
                if (pmem_resp) begin
                    state_nx = IDLE;
                    read_nx  = 1'b0;
                    write_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            owner            <= OWN_DATA;
            starve_cnt       <= '0;
            pmem_address     <= '0;
            pmem_byte_enable <= '0;
            pmem_wdata       <= '0;
            pmem_read        <= 1'b0;
            pmem_write       <= 1'b0;
        end else begin
            state            <= state_nx;
            owner            <= owner_nx;
            starve_cnt       <= starve_cnt_nx;
            pmem_address     <= address_nx;
            pmem_byte_enable <= byte_enable_nx;
            pmem_wdata       <= wdata_nx;
            pmem_read        <= read_nx;
            pmem_write       <= write_nx;
        end
    end

    // Response is forwarded combinationally so the requester sees it in the pmem_resp cycle.
    always_comb begin
        inst_mem_resp  = 1'b0;
        inst_mem_rdata = '0;
        data_mem_resp  = 1'b0;
        data_mem_rdata = '0;
        if (state == BUSY && pmem_resp) begin
            if (owner == OWN_INST) begin
                inst_mem_resp  = 1'b1;
                inst_mem_rdata = pmem_rdata;
            end else begin
                data_mem_resp  = 1'b1;
                data_mem_rdata = pmem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a transaction-level model predicts
// each pmem grant and each routed response; a negedge monitor pops and compares.
module tb_mem_port_arbiter;

    localparam int unsigned MAX_STARVE = 4;

    logic        clk;
    logic        rst;
    logic [31:0] inst_mem_address, data_mem_address;
    logic        inst_mem_read, inst_mem_write, data_mem_read, data_mem_write;
    logic [3:0]  inst_mem_byte_enable, data_mem_byte_enable;
    logic [31:0] inst_mem_wdata, data_mem_wdata;
    logic [31:0] inst_mem_rdata, data_mem_rdata;
    logic        inst_mem_resp, data_mem_resp;
    logic [31:0] pmem_address, pmem_wdata, pmem_rdata;
    logic        pmem_read, pmem_write, pmem_resp;
    logic [3:0]  pmem_byte_enable;

    mem_port_arbiter #(.MAX_STARVE(MAX_STARVE)) dut (
        .clk(clk), .rst(rst),
        .inst_mem_address(inst_mem_address), .inst_mem_read(inst_mem_read),
        .inst_mem_write(inst_mem_write), .inst_mem_byte_enable(inst_mem_byte_enable),
        .inst_mem_wdata(inst_mem_wdata), .inst_mem_rdata(inst_mem_rdata),
        .inst_mem_resp(inst_mem_resp),
        .data_mem_address(data_mem_address), .data_mem_read(data_mem_read),
        .data_mem_write(data_mem_write), .data_mem_byte_enable(data_mem_byte_enable),
        .data_mem_wdata(data_mem_wdata), .data_mem_rdata(data_mem_rdata),
        .data_mem_resp(data_mem_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_byte_enable(pmem_byte_enable), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
        int          cyc;
    } grant_t;

    typedef struct {
        int          who;    // 0 = inst, 1 = data
        logic [31:0] rdata;
        int          cyc;
    } resp_t;

    grant_t exp_grant[$];
    resp_t  exp_resp[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic rst_at_edge = 1'b0;

    // Requester model, index 0 = inst, 1 = data
    bit          act [2];
    bit          rd  [2];
    bit          wr  [2];
    logic [31:0] addr[2];
    logic [3:0]  be  [2];
    logic [31:0] wd  [2];

    // Transaction-level arbiter/memory model
    bit m_busy = 0;
    int owner = 0;
    int starve = 0;
    int mem_cnt = 0;
    bit resp_now = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, actual, expected);
        end
    endtask

    task automatic new_req(input int i);
        int op;
        op      = $urandom_range(0, 2);
        act[i]  = 1;
        rd[i]   = (op != 1);
        wr[i]   = (op != 0);
        addr[i] = (i == 1 ? 32'h8000_0000 : 32'h0) | ($urandom & 32'h0000_fffc);
        be[i]   = 4'($urandom_range(0, 15));
        wd[i]   = $urandom;
    endtask

    task automatic apply_inputs();
        inst_mem_read        = act[0] & rd[0];
        inst_mem_write       = act[0] & wr[0];
        inst_mem_address     = addr[0];
        inst_mem_byte_enable = be[0];
        inst_mem_wdata       = wd[0];
        data_mem_read        = act[1] & rd[1];
        data_mem_write       = act[1] & wr[1];
        data_mem_address     = addr[1];
        data_mem_byte_enable = be[1];
        data_mem_wdata       = wd[1];
    endtask

    // One clock: evaluate the model on the edge, then drive the next cycle's inputs.
    task automatic step(input int unsigned rate, input bit allow_rst, input bit force_rst);
        grant_t g;
        resp_t  r;
        @(posedge clk);
        cyc++;
        rst_at_edge = rst;
        if (!rst) begin
            m_busy  = 0;
            starve  = 0;
            mem_cnt = 0;
        end else if (m_busy) begin
            if (resp_now) begin
                m_busy     = 0;
                act[owner] = 0;
            end
        end else if (act[0] || act[1]) begin
            if (act[1] && (!act[0] || starve < int'(MAX_STARVE))) begin
                owner = 1;
                if (act[0]) starve = starve + 1;
            end else begin
                owner  = 0;
                starve = 0;
            end
            g.addr  = addr[owner];
            g.be    = be[owner];
            g.wdata = wd[owner];
            g.rd    = rd[owner] & ~wr[owner];
            g.wr    = wr[owner];
            g.cyc   = cyc;
            exp_grant.push_back(g);
            m_busy  = 1;
            mem_cnt = $urandom_range(1, 4);
        end

        #1;
        resp_now   = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = $urandom;
        if (force_rst || (allow_rst && $urandom_range(0, 63) == 0)) begin
            rst     = 1'b0;
            mem_cnt = 0;
        end else begin
            rst = 1'b1;
        end

        if (rst && m_busy && mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                pmem_resp = 1'b1;
                resp_now  = 1;
                r.who     = owner;
                r.rdata   = pmem_rdata;
                r.cyc     = cyc;
                exp_resp.push_back(r);
            end
        end else if (rst && !m_busy && $urandom_range(0, 7) == 0) begin
            pmem_resp = 1'b1;    // stray response while idle
        end

        for (int i = 0; i < 2; i++) begin
            if (!act[i]) begin
                if ($urandom_range(0, 99) < rate) new_req(i);
            end else if (m_busy && owner == i && $urandom_range(0, 3) == 0) begin
                addr[i] = addr[i] ^ 32'h0000_0f00;
                be[i]   = ~be[i];
                wd[i]   = $urandom;
            end
        end
        apply_inputs();
    endtask

    // Monitor
    grant_t cur;
    bit     cur_valid = 0;

    always @(negedge clk) begin
        grant_t g;
        resp_t  r;
        if (cyc > 0) begin
            if (!rst_at_edge) begin
                check("reset_pmem", {pmem_read, pmem_write, pmem_byte_enable, pmem_address}, 64'd0);
                check("reset_resp", {inst_mem_resp, data_mem_resp, pmem_wdata}, 64'd0);
                check("reset_rdata", {inst_mem_rdata, data_mem_rdata}, 64'd0);
                cur_valid = 0;
            end else if (pmem_read || pmem_write) begin
                if (!cur_valid) begin
                    check("grant_expected", exp_grant.size() != 0, 1);
                    if (exp_grant.size() != 0) begin
                        g = exp_grant.pop_front();
                        check("grant_cycle", cyc, g.cyc);
                        check("grant_addr", pmem_address, g.addr);
                        check("grant_be_wdata", {pmem_byte_enable, pmem_wdata}, {g.be, g.wdata});
                        check("grant_rw", {pmem_read, pmem_write}, {g.rd, g.wr});
                        cur       = g;
                        cur_valid = 1;
                    end
                end else begin
                    check("busy_hold", {pmem_read, pmem_write, pmem_byte_enable, pmem_address},
                          {cur.rd, cur.wr, cur.be, cur.addr});
                    check("busy_hold_wdata", pmem_wdata, cur.wdata);
                end
            end else begin
                cur_valid = 0;
            end

            if (exp_grant.size() != 0 && exp_grant[0].cyc < cyc) begin
                check("grant_missed", cyc, exp_grant[0].cyc);
                void'(exp_grant.pop_front());
            end

            if (inst_mem_resp || data_mem_resp) begin
                check("resp_expected", exp_resp.size() != 0, 1);
                if (exp_resp.size() != 0) begin
                    r = exp_resp.pop_front();
                    check("resp_cycle", cyc, r.cyc);
                    check("resp_port", {inst_mem_resp, data_mem_resp}, (r.who == 1) ? 2'b01 : 2'b10);
                    check("resp_rdata", (r.who == 1) ? data_mem_rdata : inst_mem_rdata, r.rdata);
                    check("other_rdata", (r.who == 1) ? inst_mem_rdata : data_mem_rdata, 32'd0);
                end
            end
            if (exp_resp.size() != 0 && exp_resp[0].cyc < cyc) begin
                check("resp_missed", cyc, exp_resp[0].cyc);
                void'(exp_resp.pop_front());
            end
        end
    end

    initial begin
        bit done;
        rst        = 1'b0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        new_req(0);
        new_req(1);
        apply_inputs();

        step(100, 0, 1);
        step(100, 0, 1);
        for (int i = 0; i < 1500; i++) step(100, 1, 0);
        for (int i = 0; i < 2500; i++) step(40, 1, 0);

        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            step(0, 0, 0);
            done = !act[0] && !act[1] && !m_busy;
        end
        check("drain_complete", done, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        @(negedge clk);
        #1;
        check("grant_queue_empty", exp_grant.size(), 0);
        check("resp_queue_empty", exp_resp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
